cv_maxpool_col: RTL

Column-streaming 2x2/stride-2 max-pooling stage that sits directly downstream of the 4x4 convolution column filter. It accepts one valid FP16 output column per `valid_in` pulse, pairs consecutive columns of the same feature-map row sweep, and emits one pooled column per pair. Optional ReLU is applied before the result is output. The output feeds the next convolution layer's column input.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/fp16_max2.sv | 10 +
 rtl/cv_maxpool_col.sv | 53 +++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FP16 width, +0 constant, bitwise FP16 max and ReLU helpers
package cnn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] FP16_POS_ZERO = '0;
  function automatic logic [DATA_WIDTH-1:0] fp16_max(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma, mb;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (ma == '0 && mb == '0) return FP16_POS_ZERO;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return a[DATA_WIDTH-1] ? b : a;
    return a[DATA_WIDTH-1] ? ((ma <= mb) ? a : b) : ((ma >= mb) ? a : b);
  endfunction
  function automatic logic [DATA_WIDTH-1:0] fp16_relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? FP16_POS_ZERO : x;
  endfunction
endpackage

// File: rtl/fp16_max2.sv
// fp16_max2: combinational FP16 max of a and b onto y
module fp16_max2
  import cnn_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  assign y = fp16_max(a, b);
endmodule

// File: rtl/cv_maxpool_col.sv
// cv_maxpool_col: 2x2/2 FP16 column max-pool; clk/rst, map_start, valid_in+input_column in, output_column+valid_out+map_done out
module cv_maxpool_col #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_SIZE   = 2,
  parameter int MAP_COLS   = 8,
  parameter int RELU       = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    map_start,
  input  logic                                    valid_in,
  input  logic [COL_SIZE-1:0][DATA_WIDTH-1:0]     input_column,
  output logic [COL_SIZE/2-1:0][DATA_WIDTH-1:0]   output_column,
  output logic                                    valid_out,
  output logic                                    map_done
);
  import cnn_pkg::*;
  localparam int HALF = COL_SIZE / 2;
  localparam int CW = $clog2(MAP_COLS);
  localparam bit ODD = (MAP_COLS % 2) == 1;
  localparam logic [CW-1:0] LAST = CW'(MAP_COLS - 1);
  localparam logic [CW-1:0] PAIR_END = CW'(ODD ? MAP_COLS - 2 : MAP_COLS - 1);
  logic [CW-1:0] col_idx, eff_idx, next_idx;
  logic [HALF-1:0][DATA_WIDTH-1:0] hold, vmax, hmax, pooled;
  logic even_take, odd_take;
  always_comb begin
    eff_idx = map_start ? '0 : col_idx;
    next_idx = (eff_idx == LAST) ? '0 : eff_idx + 1'b1;
    odd_take = valid_in && eff_idx[0];
    even_take = valid_in && !eff_idx[0] && !(ODD && eff_idx == LAST);
  end
  for (genvar g = 0; g < HALF; g++) begin : g_pool
    fp16_max2 u_v (.a(input_column[2*g]), .b(input_column[2*g+1]), .y(vmax[g]));
    fp16_max2 u_h (.a(hold[g]), .b(vmax[g]), .y(hmax[g]));
    assign pooled[g] = (RELU != 0) ? fp16_relu(hmax[g]) : hmax[g];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx <= '0;
      hold <= '0;
      output_column <= '0;
      valid_out <= 1'b0;
      map_done <= 1'b0;
    end else begin
      valid_out <= odd_take;
      map_done <= odd_take && eff_idx == PAIR_END;
      if (valid_in || map_start) col_idx <= valid_in ? next_idx : '0;
      if (even_take) hold <= vmax;
      else if (map_start && !valid_in) hold <= '0;
      if (odd_take) output_column <= pooled;
    end
  end
endmodule
